// File: rtl/calc_key_decoder_pkg.sv
// Shared definitions for the calculator key decoder.
//   - key codes for operators and control keys (digits are 0x00-0x0F)
//   - ALU opcode and decoder state enums
//   - key classification helpers
package calc_key_decoder_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_WAIT = 2'd2,
    S_RES  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return !k[4];
  endfunction

  function automatic logic is_op(input logic [4:0] k);
    return k inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_AND, KEY_OR};
  endfunction

  function automatic alu_op_t key_to_op(input logic [4:0] k);
    case (k)
      KEY_SUB: return ALU_SUB;
      KEY_MUL: return ALU_MUL;
      KEY_AND: return ALU_AND;
      KEY_OR:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_key_decoder_if.sv
// Bundle between the key decoder, the keypad cursor and the ALU.
//   master : the decoder (consumes keys and ALU results, drives operands/display)
//   slave  : the environment (cursor + ALU)
interface calc_key_decoder_if #(parameter int DIGITS = 4);
  localparam int W = 4 * DIGITS;

  logic         key_valid;
  logic [4:0]   key_val;
  logic         dec_mode;
  logic         restriction;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   alu_op;
  logic         alu_start;
  logic         busy;
  logic [W-1:0] disp_val;

  modport master (
    input  key_valid, key_val, dec_mode, alu_done, alu_result,
    output restriction, op_a, op_b, alu_op, alu_start, busy, disp_val
  );

  modport slave (
    output key_valid, key_val, dec_mode, alu_done, alu_result,
    input  restriction, op_a, op_b, alu_op, alu_start, busy, disp_val
  );
endinterface

// File: rtl/calc_key_decoder_operand_reg.sv
// One operand: nibble shift register plus a digit counter.
//   i_clr   : value and count to 0 (highest priority)
//   i_load  : value = single digit, count = 1
//   i_set   : value = i_value (chained result), count = full
//   i_shift : append digit if count < DIGITS; further digits are dropped
//   o_val / o_cnt : current value and digit count
module calc_key_decoder_operand_reg #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_set,
  input  logic          i_shift,
  input  logic [3:0]    i_digit,
  input  logic [W-1:0]  i_value,
  output logic [W-1:0]  o_val,
  output logic [CW-1:0] o_cnt
);
  logic [W-1:0]  r_val;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_val <= W'(i_digit);
      r_cnt <= CW'(1);
    end else if (i_set) begin
      // a chained result fills the operand; no more digits fit
      r_val <= i_value;
      r_cnt <= CW'(DIGITS);
    end else if (i_shift && (r_cnt < CW'(DIGITS))) begin
      r_val <= {r_val[W-5:0], i_digit};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_val = r_val;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/calc_key_decoder.sv
// Calculator key decoder: turns key strobes into operands A/B and an ALU
// opcode, launches the ALU with a start/done handshake and picks the
// value for the display.
//   clk, rst_n : clock, async active-low reset
//   bus        : key input, dec_mode/restriction, ALU handshake, display
module calc_key_decoder
  import calc_key_decoder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  calc_key_decoder_if.master    bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t        r_state, w_next;
  logic [W-1:0]  r_result;
  alu_op_t       r_alu_op;
  logic          r_alu_start;

  logic [W-1:0]  w_a_val, w_b_val;
  logic [CW-1:0] w_a_cnt, w_b_cnt;

  // key classification
  logic [4:0] w_k;
  logic       w_dig, w_op, w_exe, w_ce, w_clr;
  logic       w_in_a, w_in_b, w_in_wait, w_in_res;
  logic       w_b_empty, w_launch, w_done, w_wipe;

  assign w_k       = bus.key_val;
  assign w_dig     = bus.key_valid && is_digit(w_k) && !(bus.dec_mode && (w_k[3:0] > 4'd9));
  assign w_op      = bus.key_valid && is_op(w_k);
  assign w_exe     = bus.key_valid && (w_k == KEY_EXE);
  assign w_ce      = bus.key_valid && (w_k == KEY_CE);
  assign w_clr     = bus.key_valid && (w_k == KEY_CLR);

  assign w_in_a    = (r_state == S_A);
  assign w_in_b    = (r_state == S_B);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_in_res  = (r_state == S_RES);

  assign w_b_empty = (w_b_cnt == '0);
  assign w_launch  = w_in_b && w_exe && !w_b_empty;
  // CLR wins over a simultaneous alu_done; that result is dropped
  assign w_done    = w_in_wait && bus.alu_done && !w_clr;
  // full return to the power-on picture
  assign w_wipe    = w_clr || (w_in_res && w_ce);

  // A's digit count is only needed inside the operand register itself
  logic w_unused_a_cnt;
  assign w_unused_a_cnt = &{1'b0, w_a_cnt};

  calc_key_decoder_operand_reg #(.DIGITS(DIGITS)) u_op_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_wipe || (w_in_a && w_ce)),
    .i_load  (w_in_res && w_dig),
    .i_set   (w_in_res && w_op),
    .i_shift (w_in_a && w_dig),
    .i_digit (w_k[3:0]),
    .i_value (r_result),
    .o_val   (w_a_val),
    .o_cnt   (w_a_cnt)
  );

  calc_key_decoder_operand_reg #(.DIGITS(DIGITS)) u_op_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_wipe || (w_in_b && w_ce) || (w_in_a && w_op) ||
              (w_in_res && (w_dig || w_op))),
    .i_load  (1'b0),
    .i_set   (1'b0),
    .i_shift (w_in_b && w_dig),
    .i_digit (w_k[3:0]),
    .i_value ('0),
    .o_val   (w_b_val),
    .o_cnt   (w_b_cnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_A;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    if (w_clr) begin
      w_next = S_A;
    end else begin
      case (r_state)
        S_A:     if (w_op)          w_next = S_B;
        S_B:     if (w_launch)      w_next = S_WAIT;
        S_WAIT:  if (bus.alu_done)  w_next = S_RES;
        S_RES: begin
          if (w_dig || w_ce)        w_next = S_A;
          else if (w_op)            w_next = S_B;
        end
        default:                    w_next = S_A;
      endcase
    end
  end

  // result, opcode and launch pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_alu_op    <= ALU_ADD;
      r_alu_start <= 1'b0;
    end else begin
      r_alu_start <= w_launch;
      if (w_wipe) begin
        r_result <= '0;
        r_alu_op <= ALU_ADD;
      end else begin
        if (w_done) r_result <= bus.alu_result;
        // in S_B the operator may only be changed before B gets digits
        if (w_op && (w_in_a || w_in_res || (w_in_b && w_b_empty)))
          r_alu_op <= key_to_op(w_k);
      end
    end
  end

  // outputs
  always_comb begin
    bus.restriction = bus.dec_mode;
    bus.op_a        = w_a_val;
    bus.op_b        = w_b_val;
    bus.alu_op      = r_alu_op;
    bus.alu_start   = r_alu_start;
    bus.busy        = w_in_wait;
    case (r_state)
      S_A:     bus.disp_val = w_a_val;
      S_B:     bus.disp_val = w_b_empty ? w_a_val : w_b_val;
      S_WAIT:  bus.disp_val = w_b_val;
      default: bus.disp_val = r_result;
    endcase
  end
endmodule
